// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC opcodes, header layout, header pack and state enum
package noc_pkg;

    localparam int ID_W = 6;

    localparam logic [2:0] OP_MACK   = 3'd1;
    localparam logic [2:0] OP_MDATA  = 3'd2;
    localparam logic [2:0] OP_QM     = 3'd3;
    localparam logic [2:0] OP_MPUT   = 3'd4;
    localparam logic [2:0] OP_MGET   = 3'd5;
    localparam logic [2:0] OP_MLOAD  = 3'd6;
    localparam logic [2:0] OP_MSTORE = 3'd7;

    localparam int HDR_HL_BIT   = 28;
    localparam int HDR_CODE_LSB = 25;
    localparam int HDR_SRC_LSB  = 18;
    localparam int HDR_OFS_LSB  = 6;
    localparam int HDR_DEST_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_PAYLD,
        ST_RD,
        ST_LD,
        ST_SEND,
        ST_WAITR
    } noc_state_e;

    function automatic logic [31:0] pack_hdr1(
        input logic            hl,
        input logic [2:0]      code,
        input logic [ID_W-1:0] src,
        input logic [11:0]     ofs,
        input logic [ID_W-1:0] dest
    );
        return (32'(hl)   << HDR_HL_BIT)
             | (32'(code) << HDR_CODE_LSB)
             | (32'(src)  << HDR_SRC_LSB)
             | (32'(ofs)  << HDR_OFS_LSB)
             | (32'(dest) << HDR_DEST_LSB);
    endfunction

    function automatic logic is_req_code(input logic [2:0] code);
        return (code == OP_MPUT) || (code == OP_MGET) || (code == OP_MLOAD)
            || (code == OP_MSTORE) || (code == OP_QM);
    endfunction

    // Burst packets stream their payload out of the local scratchpad.
    function automatic logic is_burst(input logic [2:0] code);
        return (code == OP_MPUT) || (code == OP_QM);
    endfunction

    function automatic logic is_blocking(input logic [2:0] code);
        return (code == OP_MLOAD) || (code == OP_MSTORE);
    endfunction

endpackage

// File: rtl/noc_encoder_if.sv
// rtl/noc_encoder_if.sv - request handshake and outbound stream interfaces
interface noc_req_if #(
    parameter int BW    = 32,
    parameter int XY_SZ = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_code;
    logic                 req_hl;
    logic [2*XY_SZ-1:0]   req_dest;
    logic [31:0]          req_addr;
    logic [3:0]           req_len;
    logic [31:0]          req_laddr;
    logic [BW-1:0]        req_wdata;

    modport master (
        output req_valid, req_code, req_hl, req_dest, req_addr, req_len, req_laddr, req_wdata,
        input  req_ready
    );
    modport slave (
        input  req_valid, req_code, req_hl, req_dest, req_addr, req_len, req_laddr, req_wdata,
        output req_ready
    );
endinterface

interface noc_stream_if #(
    parameter int BW = 32
);
    localparam int BWB = BW / 8;

    logic           stream_out_TREADY;
    logic           stream_out_TVALID;
    logic [BW-1:0]  stream_out_TDATA;
    logic [BWB-1:0] stream_out_TKEEP;
    logic           stream_out_TLAST;

    modport master (
        input  stream_out_TREADY,
        output stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST
    );
    modport slave (
        output stream_out_TREADY,
        input  stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST
    );
endinterface

// File: rtl/noc_hdr_pack.sv
// rtl/noc_hdr_pack.sv - combinational header1 builder shared by encoder and decoder
module noc_hdr_pack
    import noc_pkg::*;
(
    input  logic            hl,
    input  logic [2:0]      code,
    input  logic [ID_W-1:0] src,
    input  logic [ID_W-1:0] dest,
    input  logic [11:0]     addr_ofs,
    input  logic [3:0]      len,
    output logic [31:0]     hdr
);
    logic [3:0]  len_get;
    logic [3:0]  len_put;
    logic [11:0] ofs;

    // Long form moves the address out to its own word and reuses the offset for burst lengths.
    always_comb begin
        len_get = (code == OP_MGET) ? len : 4'd0;
        len_put = (code == OP_MPUT) ? len : 4'd0;
        ofs     = hl ? {2'b00, len_get, len_put, 2'b00} : addr_ofs;
        hdr     = pack_hdr1(hl, code, src, ofs, dest);
    end
endmodule

// File: rtl/noc_encoder.sv
// rtl/noc_encoder.sv - outbound NoC request initiator: serialises one request into a packet
module noc_encoder
    import noc_pkg::*;
#(
    parameter int BW    = 32,
    parameter int BWB   = BW / 8,
    parameter int XY_SZ = 3
) (
    input  logic                clk_ctrl,
    input  logic                clk_ctrl_rst_low,
    input  logic [2*XY_SZ-1:0]  HsrcId,
    noc_req_if.slave            req,
    noc_stream_if.master        stream_out,
    input  logic                unblock,
    output logic                blocked,
    output logic                mem_valid_b,
    output logic [31:0]         mem_addr_b,
    input  logic [BW-1:0]       mem_rdata_b
);
    noc_state_e      state_q, state_d;
    logic            rdy_en_q;
    logic [2:0]      code_q;
    logic            hl_q;
    logic [ID_W-1:0] dest_q;
    logic [31:0]     addr_q;
    logic [3:0]      len_q;
    logic [31:0]     laddr_q;
    logic [BW-1:0]   wdata_q;
    logic [14:0]     cnt_q;
    logic [BW-1:0]   hold_q;

    logic            accept;
    logic            legal;
    logic            beat_fire;
    logic            tvalid;
    logic            tlast;
    logic [BW-1:0]   tdata;
    logic [31:0]     hdr1;
    logic [ID_W-1:0] src_id;
    noc_state_e      done_state;

    assign src_id    = ID_W'(HsrcId);
    assign req.req_ready = rdy_en_q && (state_q == ST_IDLE);
    assign accept    = req.req_valid && req.req_ready;
    assign legal     = is_req_code(req.req_code);
    assign beat_fire = tvalid && stream_out.stream_out_TREADY;
    assign done_state = is_blocking(code_q) ? ST_WAITR : ST_IDLE;

    noc_hdr_pack u_hdr_pack (
        .hl       (hl_q),
        .code     (code_q),
        .src      (src_id),
        .dest     (dest_q),
        .addr_ofs (addr_q[11:0]),
        .len      (len_q),
        .hdr      (hdr1)
    );

    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && legal) state_d = ST_HDR1;
            ST_HDR1:  if (beat_fire) state_d = hl_q ? ST_HDR2 : ST_PAYLD;
            ST_HDR2:  if (beat_fire) state_d = ST_PAYLD;
            ST_PAYLD: begin
                if (is_burst(code_q)) state_d = ST_RD;
                else if (beat_fire)   state_d = done_state;
            end
            ST_RD:    state_d = ST_LD;
            ST_LD:    state_d = ST_SEND;
            ST_SEND:  if (beat_fire) state_d = (cnt_q == 15'd0) ? done_state : ST_RD;
            ST_WAITR: if (unblock) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs depend only on registered state so TDATA/TLAST hold steady across stalls.
    always_comb begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        case (state_q)
            ST_HDR1: begin
                tvalid = 1'b1;
                tdata  = BW'(hdr1);
            end
            ST_HDR2: begin
                tvalid = 1'b1;
                tdata  = BW'(addr_q);
            end
            ST_PAYLD: begin
                if (!is_burst(code_q)) begin
                    tvalid = 1'b1;
                    tlast  = 1'b1;
                    tdata  = (code_q == OP_MSTORE) ? wdata_q
                                                   : BW'({14'h0, src_id, laddr_q[11:0]});
                end
            end
            ST_SEND: begin
                tvalid = 1'b1;
                tlast  = (cnt_q == 15'd0);
                tdata  = hold_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            rdy_en_q <= 1'b0;
            code_q   <= '0;
            hl_q     <= 1'b0;
            dest_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            laddr_q  <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept && legal) begin
                code_q  <= req.req_code;
                hl_q    <= req.req_hl && (req.req_code != OP_QM);
                dest_q  <= ID_W'(req.req_dest);
                addr_q  <= req.req_addr;
                len_q   <= is_blocking(req.req_code) ? 4'd0 : req.req_len;
                laddr_q <= req.req_laddr;
                wdata_q <= req.req_wdata;
                // len=15 wraps 1<<15 to zero, leaving 15'h7FFF.
                cnt_q   <= is_blocking(req.req_code) ? 15'd0
                                                     : (15'd1 << req.req_len) - 15'd1;
            end
            if (state_q == ST_LD) begin
                hold_q <= mem_rdata_b;
            end
            if ((state_q == ST_SEND) && beat_fire && (cnt_q != 15'd0)) begin
                cnt_q   <= cnt_q - 15'd1;
                laddr_q <= laddr_q + 32'd1;
            end
        end
    end

    assign blocked     = (state_q == ST_WAITR);
    assign mem_valid_b = (state_q == ST_RD);
    assign mem_addr_b  = laddr_q;

    assign stream_out.stream_out_TVALID = tvalid;
    assign stream_out.stream_out_TDATA  = tdata;
    assign stream_out.stream_out_TLAST  = tlast;
    assign stream_out.stream_out_TKEEP  = {BWB{1'b1}};

endmodule

// File: tb/tb_noc_encoder.sv
// tb/tb_noc_encoder.sv - directed self-checking bench for noc_encoder
module tb_noc_encoder;
    import noc_pkg::*;

    logic        clk_ctrl = 1'b0;
    logic        clk_ctrl_rst_low = 1'b0;
    logic [5:0]  HsrcId = 6'h12;
    logic        unblock = 1'b0;
    logic        blocked;
    logic        mem_valid_b;
    logic [31:0] mem_addr_b;
    logic [31:0] mem_rdata_b = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] bd[$];
    logic        bl[$];

    always #5 clk_ctrl = ~clk_ctrl;

    noc_req_if    #(.BW(32), .XY_SZ(3)) req_bus ();
    noc_stream_if #(.BW(32))            so ();

    noc_encoder #(.BW(32), .BWB(4), .XY_SZ(3)) dut (
        .clk_ctrl         (clk_ctrl),
        .clk_ctrl_rst_low (clk_ctrl_rst_low),
        .HsrcId           (HsrcId),
        .req              (req_bus),
        .stream_out       (so),
        .unblock          (unblock),
        .blocked          (blocked),
        .mem_valid_b      (mem_valid_b),
        .mem_addr_b       (mem_addr_b),
        .mem_rdata_b      (mem_rdata_b)
    );

    always @(posedge clk_ctrl) begin
        if (mem_valid_b) mem_rdata_b <= 32'hA000_0000 | mem_addr_b;
    end

    always @(negedge clk_ctrl) begin
        if (clk_ctrl_rst_low && so.stream_out_TVALID && so.stream_out_TREADY) begin
            bd.push_back(so.stream_out_TDATA);
            bl.push_back(so.stream_out_TLAST);
        end
    end

    task automatic tick();
        @(posedge clk_ctrl);
        #1;
    endtask

    task automatic send_req(input logic [2:0] code, input logic hl, input logic [5:0] dest,
                            input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] laddr, input logic [31:0] wdata);
        int n = 0;
        while (!req_bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (req_bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait got %0b want 1", req_bus.req_ready);
        end
        req_bus.req_code  = code;
        req_bus.req_hl    = hl;
        req_bus.req_dest  = dest;
        req_bus.req_addr  = addr;
        req_bus.req_len   = len;
        req_bus.req_laddr = laddr;
        req_bus.req_wdata = wdata;
        req_bus.req_valid = 1'b1;
        tick();
        req_bus.req_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (bd.size() < n && k < budget) begin
            @(negedge clk_ctrl);
            k++;
        end
        checks++;
        if (bd.size() < n) begin
            errors++;
            $display("FAIL beat_timeout got %0d beats want %0d", bd.size(), n);
        end
        tick();
    endtask

    task automatic wait_tvalid(input int budget);
        int k = 0;
        while (!so.stream_out_TVALID && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (so.stream_out_TVALID !== 1'b1) begin
            errors++;
            $display("FAIL tvalid_timeout got %0b want 1", so.stream_out_TVALID);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (so.stream_out_TVALID !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0b want 0", so.stream_out_TVALID); end
        checks++; if (so.stream_out_TLAST !== 1'b0)  begin errors++; $display("FAIL rst_tlast got %0b want 0", so.stream_out_TLAST); end
        checks++; if (blocked !== 1'b0)              begin errors++; $display("FAIL rst_blocked got %0b want 0", blocked); end
        checks++; if (mem_valid_b !== 1'b0)          begin errors++; $display("FAIL rst_mem_valid got %0b want 0", mem_valid_b); end
        tick();
        clk_ctrl_rst_low = 1'b1;
        checks++; if (req_bus.req_ready !== 1'b0)    begin errors++; $display("FAIL rst_ready_early got %0b want 0", req_bus.req_ready); end
        tick();
        checks++; if (req_bus.req_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready_after got %0b want 1", req_bus.req_ready); end
    endtask

    task automatic test_mstore();
        bd.delete(); bl.delete();
        send_req(OP_MSTORE, 1'b0, 6'h09, 32'h0000_0010, 4'd0, 32'h0, 32'hCAFE_F00D);
        checks++; if (so.stream_out_TKEEP !== 4'hF) begin errors++; $display("FAIL mstore_tkeep got %h want f", so.stream_out_TKEEP); end
        wait_beats(2, 20);
        repeat (3) tick();
        checks++; if (bd.size() != 2) begin errors++; $display("FAIL mstore_count got %0d want 2", bd.size()); end
        if (bd.size() == 2) begin
            checks++; if (bd[0] !== 32'h0E48_0409 || bl[0] !== 1'b0) begin errors++; $display("FAIL mstore_hdr got %h/%0b want 0e480409/0", bd[0], bl[0]); end
            checks++; if (bd[1] !== 32'hCAFE_F00D || bl[1] !== 1'b1) begin errors++; $display("FAIL mstore_data got %h/%0b want cafef00d/1", bd[1], bl[1]); end
        end
        checks++; if (blocked !== 1'b1)           begin errors++; $display("FAIL mstore_blocked got %0b want 1", blocked); end
        checks++; if (req_bus.req_ready !== 1'b0) begin errors++; $display("FAIL mstore_ready_blk got %0b want 0", req_bus.req_ready); end
        unblock = 1'b1;
        tick();
        unblock = 1'b0;
        checks++; if (blocked !== 1'b0)           begin errors++; $display("FAIL mstore_unblocked got %0b want 0", blocked); end
        checks++; if (req_bus.req_ready !== 1'b1) begin errors++; $display("FAIL mstore_ready_after got %0b want 1", req_bus.req_ready); end
    endtask

    task automatic test_mput_long();
        logic [31:0] exp_d[6];
        exp_d[0] = 32'h1848_0205;
        exp_d[1] = 32'h8000_0000;
        exp_d[2] = 32'hA000_0020;
        exp_d[3] = 32'hA000_0021;
        exp_d[4] = 32'hA000_0022;
        exp_d[5] = 32'hA000_0023;
        bd.delete(); bl.delete();
        send_req(OP_MPUT, 1'b1, 6'h05, 32'h8000_0000, 4'd2, 32'h20, 32'h0);
        wait_beats(6, 60);
        repeat (10) tick();
        checks++; if (bd.size() != 6) begin errors++; $display("FAIL mput_count got %0d want 6", bd.size()); end
        if (bd.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (bd[i] !== exp_d[i] || bl[i] !== (i == 5)) begin
                    errors++;
                    $display("FAIL mput_beat%0d got %h/%0b want %h/%0b", i, bd[i], bl[i], exp_d[i], (i == 5));
                end
            end
        end
        checks++; if (blocked !== 1'b0) begin errors++; $display("FAIL mput_blocked got %0b want 0", blocked); end
    endtask

    task automatic test_mget();
        bd.delete(); bl.delete();
        send_req(OP_MGET, 1'b0, 6'h03, 32'h0000_0123, 4'd0, 32'h0A4, 32'h0);
        wait_beats(2, 20);
        repeat (4) tick();
        checks++; if (bd.size() != 2) begin errors++; $display("FAIL mget_count got %0d want 2", bd.size()); end
        if (bd.size() == 2) begin
            checks++; if (bd[0] !== 32'h0A48_48C3 || bl[0] !== 1'b0) begin errors++; $display("FAIL mget_hdr got %h/%0b want 0a4848c3/0", bd[0], bl[0]); end
            checks++; if (bd[1] !== 32'h0001_20A4 || bl[1] !== 1'b1) begin errors++; $display("FAIL mget_ret got %h/%0b want 000120a4/1", bd[1], bl[1]); end
        end
        checks++; if (blocked !== 1'b0)           begin errors++; $display("FAIL mget_blocked got %0b want 0", blocked); end
        checks++; if (req_bus.req_ready !== 1'b1) begin errors++; $display("FAIL mget_ready got %0b want 1", req_bus.req_ready); end
    endtask

    task automatic test_qm_stall();
        bd.delete(); bl.delete();
        send_req(OP_QM, 1'b1, 6'h01, 32'h0000_00AB, 4'd0, 32'h40, 32'h0);
        wait_beats(1, 20);
        so.stream_out_TREADY = 1'b0;
        wait_tvalid(20);
        repeat (5) begin
            @(negedge clk_ctrl);
            checks++;
            if (so.stream_out_TVALID !== 1'b1 || so.stream_out_TDATA !== 32'hA000_0040 || so.stream_out_TLAST !== 1'b1) begin
                errors++;
                $display("FAIL qm_stall got v%0b %h l%0b want v1 a0000040 l1",
                         so.stream_out_TVALID, so.stream_out_TDATA, so.stream_out_TLAST);
            end
        end
        @(posedge clk_ctrl);
        #1;
        so.stream_out_TREADY = 1'b1;
        wait_beats(2, 20);
        repeat (6) tick();
        checks++; if (bd.size() != 2) begin errors++; $display("FAIL qm_count got %0d want 2", bd.size()); end
        if (bd.size() == 2) begin
            checks++; if (bd[0] !== 32'h0648_2AC1 || bl[0] !== 1'b0) begin errors++; $display("FAIL qm_hdr got %h/%0b want 06482ac1/0", bd[0], bl[0]); end
            checks++; if (bd[1] !== 32'hA000_0040 || bl[1] !== 1'b1) begin errors++; $display("FAIL qm_data got %h/%0b want a0000040/1", bd[1], bl[1]); end
        end
    endtask

    task automatic test_illegal();
        logic seen = 1'b0;
        bd.delete(); bl.delete();
        send_req(3'd0, 1'b0, 6'h04, 32'h0, 4'd0, 32'h0, 32'h0);
        repeat (10) begin
            @(negedge clk_ctrl);
            if (so.stream_out_TVALID) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0)              begin errors++; $display("FAIL illegal_tvalid got %0b want 0", seen); end
        checks++; if (req_bus.req_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got %0b want 1", req_bus.req_ready); end
        checks++; if (bd.size() != 0)             begin errors++; $display("FAIL illegal_beats got %0d want 0", bd.size()); end
        tick();
    endtask

    task automatic test_reset_mid();
        bd.delete(); bl.delete();
        send_req(OP_MPUT, 1'b0, 6'h02, 32'h0000_0050, 4'd3, 32'h100, 32'h0);
        wait_beats(2, 30);
        wait_tvalid(10);
        clk_ctrl_rst_low = 1'b0;
        #1;
        checks++; if (so.stream_out_TVALID !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %0b want 0", so.stream_out_TVALID); end
        checks++; if (blocked !== 1'b0)              begin errors++; $display("FAIL midrst_blocked got %0b want 0", blocked); end
        tick();
        tick();
        clk_ctrl_rst_low = 1'b1;
        bd.delete(); bl.delete();
        repeat (20) tick();
        checks++; if (bd.size() != 0) begin errors++; $display("FAIL midrst_resumed got %0d beats want 0", bd.size()); end
        send_req(OP_MGET, 1'b0, 6'h03, 32'h0000_0123, 4'd0, 32'h0A4, 32'h0);
        wait_beats(2, 20);
        repeat (4) tick();
        checks++; if (bd.size() != 2) begin errors++; $display("FAIL midrst_count got %0d want 2", bd.size()); end
        if (bd.size() == 2) begin
            checks++; if (bd[0] !== 32'h0A48_48C3) begin errors++; $display("FAIL midrst_hdr got %h want 0a4848c3", bd[0]); end
            checks++; if (bd[1] !== 32'h0001_20A4) begin errors++; $display("FAIL midrst_ret got %h want 000120a4", bd[1]); end
        end
    endtask

    initial begin
        req_bus.req_valid = 1'b0;
        req_bus.req_code  = 3'd0;
        req_bus.req_hl    = 1'b0;
        req_bus.req_dest  = 6'h0;
        req_bus.req_addr  = 32'h0;
        req_bus.req_len   = 4'd0;
        req_bus.req_laddr = 32'h0;
        req_bus.req_wdata = 32'h0;
        so.stream_out_TREADY = 1'b1;
        test_reset();
        test_mstore();
        test_mput_long();
        test_mget();
        test_qm_stall();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
